// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants and helpers for deriving line/frame geometry.
package vga_timing_pkg;

   // One axis of a video mode, in the order the beam traverses it.
   typedef struct packed {
      int unsigned sync;
      int unsigned back;
      int unsigned lead_border;
      int unsigned valid;
      int unsigned trail_border;
      int unsigned front;
   } axis_mode_t;

   // 640x480@60, 25.175 MHz pixel clock, 8-pixel/8-line borders.
   localparam axis_mode_t Mode640x480H = '{96, 40, 8, 640, 8, 8};
   localparam axis_mode_t Mode640x480V = '{2, 25, 8, 480, 8, 2};

   // 800x600@72 for a 50 MHz pixel clock, no borders.
   localparam axis_mode_t Mode800x600H = '{120, 64, 0, 800, 0, 56};
   localparam axis_mode_t Mode800x600V = '{6, 23, 0, 600, 0, 37};

   // Full period of an axis (H_TOTAL or V_TOTAL).
   function automatic int unsigned axis_total(input int unsigned sync, input int unsigned back,
                                              input int unsigned lead, input int unsigned valid,
                                              input int unsigned trail, input int unsigned front);
      return sync + back + lead + valid + trail + front;
   endfunction

   // First active position of an axis (HA or VA).
   function automatic int unsigned axis_active_start(input int unsigned sync,
                                                     input int unsigned back,
                                                     input int unsigned lead);
      return sync + back + lead;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source / display-side signal bundle of the VGA timing generator.
interface vga_timing_gen_if #(
   parameter int unsigned PIX_W = 16,
   parameter int unsigned CNT_W = 10
);
   logic             en;
   logic [PIX_W-1:0] pix_data;
   logic             pix_req;
   logic [CNT_W-1:0] pix_x;
   logic [CNT_W-1:0] pix_y;
   logic             hsync;
   logic             vsync;
   logic [PIX_W-1:0] rgb;
   logic             rgb_valid;
   logic             line_start;
   logic             frame_start;
   logic [7:0]       frame_cnt;

   // Timing generator side.
   modport master (
      input  en, pix_data,
      output pix_req, pix_x, pix_y, hsync, vsync, rgb, rgb_valid,
             line_start, frame_start, frame_cnt
   );

   // Pixel source / display side.
   modport slave (
      output en, pix_data,
      input  pix_req, pix_x, pix_y, hsync, vsync, rgb, rgb_valid,
             line_start, frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one display axis.
module vga_axis_counter #(
   parameter int unsigned TOTAL = 800,
   parameter int unsigned CNT_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             wrap_o
);
   localparam logic [CNT_W-1:0] Last = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A clear suppresses the wrap so a held-off axis never signals a period end.
   assign wrap_o = inc_i & ~clr_i & (cnt_q == Last);
   assign cnt_o  = cnt_q;

   // Next count: clear wins, then wrap, then increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (wrap_o) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/active-window generator with a look-ahead pixel request port.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = Mode640x480H.sync,
   parameter int unsigned H_BACK   = Mode640x480H.back,
   parameter int unsigned H_LEFT   = Mode640x480H.lead_border,
   parameter int unsigned H_VALID  = Mode640x480H.valid,
   parameter int unsigned H_RIGHT  = Mode640x480H.trail_border,
   parameter int unsigned H_FRONT  = Mode640x480H.front,
   parameter int unsigned V_SYNC   = Mode640x480V.sync,
   parameter int unsigned V_BACK   = Mode640x480V.back,
   parameter int unsigned V_TOP    = Mode640x480V.lead_border,
   parameter int unsigned V_VALID  = Mode640x480V.valid,
   parameter int unsigned V_BOTTOM = Mode640x480V.trail_border,
   parameter int unsigned V_FRONT  = Mode640x480V.front,
   parameter int unsigned PIX_W    = 16,
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned REQ_LAT  = 1,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1
) (
   input logic              vga_clk,
   input logic              sys_rst_n,
   vga_timing_gen_if.master bus
);
   localparam int unsigned HTotal = axis_total(H_SYNC, H_BACK, H_LEFT, H_VALID, H_RIGHT, H_FRONT);
   localparam int unsigned VTotal = axis_total(V_SYNC, V_BACK, V_TOP, V_VALID, V_BOTTOM, V_FRONT);
   localparam int unsigned Ha     = axis_active_start(H_SYNC, H_BACK, H_LEFT);
   localparam int unsigned Va     = axis_active_start(V_SYNC, V_BACK, V_TOP);

   logic [CNT_W-1:0] cnt_h, cnt_v;
   logic             h_wrap, v_wrap;

   vga_axis_counter #(
      .TOTAL (HTotal),
      .CNT_W (CNT_W)
   ) u_cnt_h (
      .clk_i  (vga_clk),
      .rst_ni (sys_rst_n),
      .clr_i  (~bus.en),
      .inc_i  (1'b1),
      .cnt_o  (cnt_h),
      .wrap_o (h_wrap)
   );

   // v_wrap is the frame wrap: the line counter only steps on an h wrap.
   vga_axis_counter #(
      .TOTAL (VTotal),
      .CNT_W (CNT_W)
   ) u_cnt_v (
      .clk_i  (vga_clk),
      .rst_ni (sys_rst_n),
      .clr_i  (~bus.en),
      .inc_i  (h_wrap),
      .cnt_o  (cnt_v),
      .wrap_o (v_wrap)
   );

   int unsigned      h_u, v_u, h_req;
   logic             act_v, act, req;
   logic             hsync_d, hsync_q, vsync_d, vsync_q;
   logic             rgb_valid_d, rgb_valid_q, pix_req_d, pix_req_q;
   logic             line_start_d, line_start_q, frame_start_d, frame_start_q;
   logic [CNT_W-1:0] pix_x_d, pix_x_q, pix_y_d, pix_y_q;
   logic [PIX_W-1:0] rgb_d, rgb_q;
   logic [7:0]       frame_cnt_d, frame_cnt_q;

   // Decode the current counter position into next-cycle outputs; en=0 gives the idle pattern.
   always_comb begin
      h_u   = 32'(cnt_h);
      v_u   = 32'(cnt_v);
      h_req = h_u + REQ_LAT;
      act_v = (v_u >= Va) && (v_u < Va + V_VALID);
      act   = act_v && (h_u >= Ha) && (h_u < Ha + H_VALID);
      req   = act_v && (h_req >= Ha) && (h_req < Ha + H_VALID);

      hsync_d       = ~HS_POL;
      vsync_d       = ~VS_POL;
      rgb_valid_d   = 1'b0;
      rgb_d         = '0;
      pix_req_d     = 1'b0;
      pix_x_d       = '1;
      pix_y_d       = '1;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (bus.en) begin
         hsync_d       = (h_u < H_SYNC) ? HS_POL : ~HS_POL;
         vsync_d       = (v_u < V_SYNC) ? VS_POL : ~VS_POL;
         rgb_valid_d   = act;
         rgb_d         = act ? bus.pix_data : '0;
         pix_req_d     = req;
         pix_x_d       = req ? CNT_W'(h_req - Ha) : '1;
         pix_y_d       = req ? CNT_W'(v_u - Va) : '1;
         line_start_d  = (h_u == 0);
         frame_start_d = (h_u == 0) && (v_u == 0);
      end
      frame_cnt_d = v_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
   end

   // Output registers; reset drives the idle pattern without waiting for a clock.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         rgb_valid_q   <= 1'b0;
         rgb_q         <= '0;
         pix_req_q     <= 1'b0;
         pix_x_q       <= '1;
         pix_y_q       <= '1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_valid_q   <= rgb_valid_d;
         rgb_q         <= rgb_d;
         pix_req_q     <= pix_req_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.rgb_valid   = rgb_valid_q;
   assign bus.rgb         = rgb_q;
   assign bus.pix_req     = pix_req_q;
   assign bus.pix_x       = pix_x_q;
   assign bus.pix_y       = pix_y_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a 17x7 mode, REQ_LAT=3, active-low syncs.
module tb_vga_timing_gen;
   // Output vector: {hsync, vsync, rgb_valid, pix_req, line_start, frame_start,
   //                 pix_x, pix_y, rgb, frame_cnt}
   localparam logic [49:0] RstVec = {6'b110000, 10'h3FF, 10'h3FF, 16'h0, 8'h0};

   logic vga_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   logic clk_run   = 1'b1;
   int   checks    = 0;
   int   errors    = 0;
   logic [15:0] s1 = '0;
   logic [15:0] s2 = '0;

   vga_timing_gen_if #(.PIX_W(16), .CNT_W(10)) bus ();

   vga_timing_gen #(
      .H_SYNC(4), .H_BACK(2), .H_LEFT(1), .H_VALID(8), .H_RIGHT(1), .H_FRONT(1),
      .V_SYNC(1), .V_BACK(1), .V_TOP(0), .V_VALID(4), .V_BOTTOM(0), .V_FRONT(1),
      .PIX_W(16), .CNT_W(10), .REQ_LAT(3), .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .vga_clk   (vga_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   initial forever #5 if (clk_run) vga_clk = ~vga_clk;

   // Two-stage pixel source: colour encodes the requested coordinates.
   always @(posedge vga_clk) begin
      s1 <= {bus.pix_y[5:0], bus.pix_x};
      s2 <= s1;
   end
   assign bus.pix_data = s2;

   function automatic logic [49:0] obs_vec();
      return {bus.hsync, bus.vsync, bus.rgb_valid, bus.pix_req, bus.line_start,
              bus.frame_start, bus.pix_x, bus.pix_y, bus.rgb, bus.frame_cnt};
   endfunction

   task automatic test_reset();
      bus.en    = 1'b1;
      sys_rst_n = 1'b0;
      repeat (3) @(negedge vga_clk);
      checks++;
      if (obs_vec() !== RstVec) begin
         errors++;
         $display("FAIL reset_values got=%h exp=%h", obs_vec(), RstVec);
      end
   endtask

   // Two frames from reset release against the mode's hand-derived timing.
   task automatic test_frame();
      int h, v, first_req, first_val, val_cnt, hs_cnt, fs_cnt;
      logic hs, vs, act, req;
      logic [9:0] px, py;
      logic [15:0] rgb_e;
      logic [7:0] fc;
      logic [49:0] exp_v;
      first_req = -1; first_val = -1; val_cnt = 0; hs_cnt = 0; fs_cnt = 0;
      sys_rst_n = 1'b1;
      for (int g = 0; g < 238; g++) begin
         @(negedge vga_clk);
         h     = g % 17;
         v     = (g / 17) % 7;
         hs    = (h < 4) ? 1'b0 : 1'b1;
         vs    = (v < 1) ? 1'b0 : 1'b1;
         act   = (h >= 7) && (h < 15) && (v >= 2) && (v < 6);
         req   = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
         px    = req ? 10'(h - 4) : 10'h3FF;
         py    = req ? 10'(v - 2) : 10'h3FF;
         rgb_e = act ? {6'(v - 2), 10'(h - 7)} : 16'h0;
         fc    = 8'((g + 1) / 119);
         exp_v = {hs, vs, act, req, (h == 0), (h == 0) && (v == 0), px, py, rgb_e, fc};
         checks++;
         if (obs_vec() !== exp_v) begin
            errors++;
            $display("FAIL frame_model g=%0d got=%h exp=%h", g, obs_vec(), exp_v);
         end
         if (bus.pix_req === 1'b1 && first_req < 0) first_req = g;
         if (bus.rgb_valid === 1'b1 && first_val < 0) first_val = g;
         if (bus.rgb_valid === 1'b1) val_cnt++;
         if (bus.hsync === 1'b0) hs_cnt++;
         if (bus.frame_start === 1'b1) fs_cnt++;
      end
      checks++;
      if (first_req != 38) begin
         errors++;
         $display("FAIL first_pix_req got=%0d exp=38", first_req);
      end
      checks++;
      if (first_val - first_req != 3) begin
         errors++;
         $display("FAIL req_lead got=%0d exp=3", first_val - first_req);
      end
      checks++;
      if (val_cnt != 64) begin
         errors++;
         $display("FAIL valid_count got=%0d exp=64", val_cnt);
      end
      checks++;
      if (hs_cnt != 56) begin
         errors++;
         $display("FAIL hsync_active_count got=%0d exp=56", hs_cnt);
      end
      checks++;
      if (fs_cnt != 2) begin
         errors++;
         $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
      end
   endtask

   // Drop en inside an active line of the third frame, hold 10 cycles, restart.
   task automatic test_enable_drop();
      int fs_cnt;
      fs_cnt = 0;
      repeat (62) @(negedge vga_clk);  // sample 299: position (10,3)
      checks++;
      if ({bus.rgb_valid, bus.frame_cnt} !== {1'b1, 8'd2}) begin
         errors++;
         $display("FAIL pre_drop got=%b/%0d exp=1/2", bus.rgb_valid, bus.frame_cnt);
      end
      bus.en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge vga_clk);
         checks++;
         if (obs_vec() !== {6'b110000, 10'h3FF, 10'h3FF, 16'h0, 8'd2}) begin
            errors++;
            $display("FAIL idle_when_disabled i=%0d got=%h", i, obs_vec());
         end
      end
      bus.en = 1'b1;
      @(negedge vga_clk);
      checks++;
      if (obs_vec() !== {6'b000011, 10'h3FF, 10'h3FF, 16'h0, 8'd2}) begin
         errors++;
         $display("FAIL restart_first_cycle got=%h exp=%h", obs_vec(),
                  {6'b000011, 10'h3FF, 10'h3FF, 16'h0, 8'd2});
      end
      for (int r = 1; r <= 118; r++) begin
         @(negedge vga_clk);
         if (bus.frame_start === 1'b1) fs_cnt++;
         if (r == 117) begin
            checks++;
            if (bus.frame_cnt !== 8'd2) begin
               errors++;
               $display("FAIL restart_frame_cnt_hold got=%0d exp=2", bus.frame_cnt);
            end
         end
         if (r == 118) begin
            checks++;
            if (bus.frame_cnt !== 8'd3) begin
               errors++;
               $display("FAIL restart_frame_cnt_inc got=%0d exp=3", bus.frame_cnt);
            end
         end
      end
      checks++;
      if (fs_cnt != 0) begin
         errors++;
         $display("FAIL restart_spurious_frame_start got=%0d exp=0", fs_cnt);
      end
   endtask

   // Reset asserted with the clock stopped mid-active must act at once.
   task automatic test_async_reset();
      int n;
      n = 0;
      while (bus.rgb_valid !== 1'b1 && n < 200) begin
         @(negedge vga_clk);
         n++;
      end
      checks++;
      if (bus.rgb_valid !== 1'b1) begin
         errors++;
         $display("FAIL wait_active got=%b exp=1 (timeout)", bus.rgb_valid);
      end
      clk_run = 1'b0;
      #7;
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (obs_vec() !== RstVec) begin
         errors++;
         $display("FAIL async_reset got=%h exp=%h", obs_vec(), RstVec);
      end
      #10 sys_rst_n = 1'b1;
      #10 clk_run = 1'b1;
   endtask

   // 256 full frames: frame_cnt climbs to 255 and wraps to 0.
   task automatic test_frame_wrap();
      int fs_cnt;
      fs_cnt = 0;
      for (int g = 0; g < 256 * 119; g++) begin
         @(negedge vga_clk);
         if (bus.frame_start === 1'b1) fs_cnt++;
         if (g == 118) begin
            checks++;
            if (bus.frame_cnt !== 8'd1) begin
               errors++;
               $display("FAIL wrap_first_inc got=%0d exp=1", bus.frame_cnt);
            end
         end
         if (g == 255 * 119 - 1) begin
            checks++;
            if (bus.frame_cnt !== 8'd255) begin
               errors++;
               $display("FAIL wrap_at_255 got=%0d exp=255", bus.frame_cnt);
            end
         end
         if (g == 256 * 119 - 1) begin
            checks++;
            if (bus.frame_cnt !== 8'd0) begin
               errors++;
               $display("FAIL wrap_to_0 got=%0d exp=0", bus.frame_cnt);
            end
         end
      end
      checks++;
      if (fs_cnt != 256) begin
         errors++;
         $display("FAIL wrap_frame_starts got=%0d exp=256", fs_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_enable_drop();
      test_async_reset();
      test_frame_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing and pixel-stream controller. It generates hsync/vsync and the active-video window for any mode set by parameters. It gives the upstream pixel source a pixel request, with pixel coordinates, a configurable number of cycles ahead of display. All outputs are registered. It adds line/frame-start strobes, a frame counter, a run enable, and programmable sync polarity. Sits between the pixel-generating game/graphics logic and the VGA DAC pins.

Parameters:
H_SYNC, 96, sync pulse width (pixel clocks)
H_BACK, 40, back porch (pixel clocks)
H_LEFT, 8, left border (pixel clocks)
H_VALID, 640, active pixels per line
H_RIGHT, 8, right border (pixel clocks)
H_FRONT, 8, front porch (pixel clocks)
V_SYNC, 2, sync width (lines)
V_BACK, 25, back porch (lines)
V_TOP, 8, top border (lines)
V_VALID, 480, active lines
V_BOTTOM, 8, bottom border (lines)
V_FRONT, 2, front porch (lines)
PIX_W, 16, colour width (RGB565 default)
CNT_W, 10, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
REQ_LAT, 1, lead of pix_req over rgb_valid in cycles; legal range 1..4, and REQ_LAT <= H_SYNC+H_BACK+H_LEFT
HS_POL, 1, active level of hsync
VS_POL, 1, active level of vsync

Ports:
vga_clk  in  1  pixel clock
sys_rst_n  in  1  asynchronous active-low reset
en  in  1  run enable, synchronous
pix_data  in  PIX_W  colour for the pixel requested REQ_LAT-1 cycles earlier
pix_req  out  1  pixel request
pix_x  out  CNT_W  requested x; all-ones when pix_req=0
pix_y  out  CNT_W  requested y; all-ones when pix_req=0
hsync  out  1  line sync
vsync  out  1  field sync
rgb  out  PIX_W  colour out; 0 outside active window
rgb_valid  out  1  active-video flag
line_start  out  1  one-cycle strobe, cnt_h==0
frame_start  out  1  one-cycle strobe, cnt_h==0 and cnt_v==0
frame_cnt  out  8  frame counter, wraps

Behaviour:
- Interface: single clock vga_clk; reset sys_rst_n is asynchronous, active-low.
- Derived values:
  - H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
  - HA = H_SYNC+H_BACK+H_LEFT; VA = V_SYNC+V_BACK+V_TOP.
- Counters:
  - cnt_h counts 0..H_TOTAL-1 and wraps.
  - cnt_v increments when cnt_h wraps, and wraps to 0 when cnt_v==V_TOTAL-1 and cnt_h==H_TOTAL-1.
  - frame_cnt increments by 1 on that same V wrap; 255 wraps to 0.
- Output registration: every output is registered. The output at edge t+1 reflects the counter state at cycle t, giving a 1-cycle latency.
- Sync:
  - hsync = HS_POL while cnt_h < H_SYNC, else ~HS_POL.
  - vsync = VS_POL while cnt_v < V_SYNC, else ~VS_POL.
- Active window:
  - act = HA <= cnt_h < HA+H_VALID, and VA <= cnt_v < VA+V_VALID.
  - rgb_valid <= act.
  - rgb <= act ? pix_data : 0.
- Pixel request:
  - req = HA <= cnt_h+REQ_LAT < HA+H_VALID, with the v range as for act.
  - pix_req <= req.
  - pix_x <= cnt_h+REQ_LAT-HA; pix_y <= cnt_v-VA; both all-ones when req=0.
  - pix_req therefore leads rgb_valid by exactly REQ_LAT cycles.
  - The source must present pix_data REQ_LAT-1 cycles after it sees the matching pix_x. With REQ_LAT=1, pix_data is combinational from pix_x.
- Enable:
  - en=0: counters held at 0; next edge drives idle outputs (syncs inactive, rgb/rgb_valid/pix_req/strobes 0, coords all-ones); frame_cnt holds.
  - en 0->1: timing restarts at (0,0). frame_start pulses on the first output cycle; frame_cnt does not increment.
  - en dropping mid-line aborts the frame with no partial-line completion.
- Reset values:
  - Counters 0; frame_cnt 0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - rgb 0, rgb_valid 0, pix_req 0, line_start 0, frame_start 0.
  - pix_x and pix_y all-ones.
  - Reset mid-frame forces these values immediately, without a clock.

Decomposition:
- Package vga_timing_pkg:
  - mode constant sets (640x480@60 default, plus 800x600@72 for a 50 MHz clock).
  - functions for H_TOTAL, V_TOTAL, HA and VA.
- Sub-module vga_axis_counter: one instance per axis.
  - wrapping counter with parameter TOTAL, inputs clr/inc, output wrap.
  - instance 1: inc=1, clr=~en; instance 2: inc = H wrap, clr=~en.

Test Plan:
- Default params, release reset with en=1 -> hsync high 96 of every 800 cycles; vsync high 1600 of every 420000 cycles; first output cycle has hsync=vsync=1.
- Default params, count rgb_valid -> first assertion at counter (144,35); 640 consecutive cycles per line; 307200 per frame; rgb=0 whenever rgb_valid=0.
- REQ_LAT=3, source is a 2-stage pipeline returning pix_data={pix_y[5:0],pix_x[9:0]} -> rgb matches (x,y) for every valid pixel; first pix_req (pix_x=0, pix_y=0) precedes first rgb_valid by 3 cycles.
- HS_POL=0, VS_POL=0, small mode (H 4/2/1/8/1/1, V 1/1/0/4/0/1) -> inverted sync levels; H_TOTAL=17; V_TOTAL=7; frame_start every 119 cycles.
- Drop en at cnt_h=300 of line 100, hold 10 cycles, raise it -> idle outputs the cycle after en falls; frame_start 1 cycle after en rises; frame_cnt unchanged.
- Assert sys_rst_n low mid-active with clock stopped -> all outputs at reset values immediately; after 256 full frames frame_cnt returns to 0.
